// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller.
// Holds the ALU opcode enum, the issue FSM state type, the instruction
// field positions and the op-index to opcode decode helper.
package alu_issue_ctrl_pkg;

    localparam int DATA_W  = 8;
    localparam int OPS_W   = 4;
    localparam int INSTR_W = 9;

    // Instruction field positions: [8:6] op index, [5:3] ra, [2:0] rb/imm3
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RA_HI = 5;
    localparam int RA_LO = 3;
    localparam int RB_HI = 2;
    localparam int RB_LO = 0;

    // Op indices with special handling in the controller
    localparam logic [2:0] OP_IDX_ADDI = 3'd0;
    localparam logic [2:0] OP_IDX_NE   = 3'd7;

    typedef enum logic [3:0] {
        ADD_IMMEDIATE      = 4'd0,
        REDUCED_XOR        = 4'd1,
        LEFT_SHIFT         = 4'd2,
        RIGHT_SHIFT        = 4'd3,
        XOR_REGISTER       = 4'd4,
        OR_REGISTER        = 4'd5,
        AND_REGISTER       = 4'd6,
        NOT_EQUAL_REGISTER = 4'd7
    } op_mne;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } issue_state_t;

    // Map the 3-bit op index of an instruction to the ALU opcode.
    function automatic op_mne decode_op(input logic [2:0] idx);
        op_mne op;
        case (idx)
            3'd0:    op = ADD_IMMEDIATE;
            3'd1:    op = REDUCED_XOR;
            3'd2:    op = LEFT_SHIFT;
            3'd3:    op = RIGHT_SHIFT;
            3'd4:    op = XOR_REGISTER;
            3'd5:    op = OR_REGISTER;
            3'd6:    op = AND_REGISTER;
            3'd7:    op = NOT_EQUAL_REGISTER;
            default: op = ADD_IMMEDIATE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// issue_regfile: 8 x W register file for the issue controller.
// Two combinational operand read ports, one combinational debug read port
// and one synchronous write port; all entries clear on asynchronous reset.
// A write lands on the clock edge, so reads in the write cycle see the old value.
module issue_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   rd_addr_a,
    output logic [W-1:0] rd_data_a,
    input  logic [2:0]   rd_addr_b,
    output logic [W-1:0] rd_data_b,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [W-1:0] wr_data
);

    logic [W-1:0] regs_r [8];

    // Register storage: clear everything on reset, single write port otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs_r[rd_addr_a];
    assign rd_data_b = regs_r[rd_addr_b];
    assign dbg_data  = regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/writeback controller feeding an external
// combinational ALU. Each instruction walks IDLE -> READ -> EXEC -> WB:
// operands are registered in READ, the ALU result is captured in EXEC, and in
// WB the result is written to R[ra] (ops 0-6) or its bit 0 latched as NeFlag (op 7).
// Optional feature macro: ALU_ISSUE_PERF_EN adds a 16-bit wrapping RetireCnt
// output counting retired instructions.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int W   = DATA_W,
    parameter int Ops = OPS_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InstrValid,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic               InstrReady,
    output logic [W-1:0]       AluA,
    output logic [W-1:0]       AluB,
    output logic [Ops-1:0]     AluInst,
    input  logic [W-1:0]       AluOut,
    output logic               NeFlag,
    output logic               Done,
    input  logic [2:0]         DbgRdAddr,
    output logic [W-1:0]       DbgRdData
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]        RetireCnt
`endif
);

    issue_state_t       state_r;
    logic [INSTR_W-1:0] instr_r;
    logic [W-1:0]       result_r;

    logic [2:0]         op_idx_s;
    logic [2:0]         ra_s;
    logic [2:0]         rb_s;
    logic [W-1:0]       rd_a_s;
    logic [W-1:0]       rd_b_s;
    logic [W-1:0]       operand_b_s;
    logic               wb_en_s;

    assign op_idx_s = instr_r[OP_HI:OP_LO];
    assign ra_s     = instr_r[RA_HI:RA_LO];
    assign rb_s     = instr_r[RB_HI:RB_LO];

    // Only register-writing ops update the file, and only in the WB cycle
    assign wb_en_s = (state_r == WB) && (op_idx_s != OP_IDX_NE);

    issue_regfile #(
        .W (W)
    ) u_regfile (
        .clk       (Clk),
        .rst       (Reset),
        .rd_addr_a (ra_s),
        .rd_data_a (rd_a_s),
        .rd_addr_b (rb_s),
        .rd_data_b (rd_b_s),
        .dbg_addr  (DbgRdAddr),
        .dbg_data  (DbgRdData),
        .wr_en     (wb_en_s),
        .wr_addr   (ra_s),
        .wr_data   (result_r)
    );

    // Operand B select: zero-extended imm3 for add_immediate, else R[rb]
    always_comb begin
        operand_b_s = rd_b_s;
        if (op_idx_s == OP_IDX_ADDI) begin
            operand_b_s = {{(W-3){1'b0}}, rb_s};
        end else begin
            operand_b_s = rd_b_s;
        end
    end

    // Issue FSM with registered ALU drive, result capture, flag and handshake
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= IDLE;
            instr_r    <= '0;
            result_r   <= '0;
            AluA       <= '0;
            AluB       <= '0;
            AluInst    <= '0;
            NeFlag     <= 1'b0;
            Done       <= 1'b0;
            InstrReady <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    Done <= 1'b0;
                    if (InstrValid && InstrReady) begin
                        instr_r    <= InstrIn;
                        InstrReady <= 1'b0;
                        state_r    <= READ;
                    end else begin
                        InstrReady <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                READ: begin
                    AluA    <= rd_a_s;
                    AluB    <= operand_b_s;
                    AluInst <= Ops'(decode_op(op_idx_s));
                    state_r <= EXEC;
                end
                EXEC: begin
                    // Operands and opcode are stable this cycle, so AluOut is valid
                    result_r <= AluOut;
                    Done     <= 1'b1;
                    state_r  <= WB;
                end
                WB: begin
                    if (op_idx_s == OP_IDX_NE) begin
                        NeFlag <= result_r[0];
                    end else begin
                        NeFlag <= NeFlag;
                    end
                    Done       <= 1'b0;
                    InstrReady <= 1'b1;
                    state_r    <= IDLE;
                end
                default: begin
                    Done       <= 1'b0;
                    InstrReady <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RetireCnt <= 16'd0;
        end else if (Done) begin
            RetireCnt <= RetireCnt + 16'd1;
        end else begin
            RetireCnt <= RetireCnt;
        end
    end
`endif

endmodule
